// File: rtl/pdm_sample_feeder.sv
// pdm_sample_feeder: FIFO-buffered PCM pacer feeding the pdm modulator.
// Define PDM_FEEDER_INTERP_EN for linear interpolation (default: hold).
module pdm_sample_feeder #(
  parameter int WIDTH      = 16,
  parameter int OSR_LOG2   = 6,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk_in,
  input  logic                          rst_n_in,
  input  logic [WIDTH-1:0]              sample_in,
  input  logic                          sample_valid_in,
  output logic                          sample_ready_out,
  output logic [WIDTH-1:0]              level_out,
  output logic                          tick_out,
  output logic                          underrun_out,
  input  logic                          clear_underrun_in,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_out
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);
  localparam logic [WIDTH-1:0] MID =
    {1'b1, {(WIDTH-1){1'b0}}};

  logic [WIDTH-1:0]    r_mem [FIFO_DEPTH];
  logic [PW-1:0]       r_wptr;
  logic [PW-1:0]       r_rptr;
  logic [CW-1:0]       r_count;
  logic                r_ready;
  logic [OSR_LOG2-1:0] r_phase;
  logic [WIDTH-1:0]    r_cur;
  logic                r_tick;
  logic                r_underrun;
  logic [WIDTH-1:0]    r_level;

  logic                w_push;
  logic                w_pop;
  logic                w_empty;
  logic                w_boundary;
  logic [CW-1:0]       w_count_next;
  logic [WIDTH-1:0]    w_cur_new;
  logic [WIDTH-1:0]    w_y;

  assign w_empty    = (r_count == '0);
  assign w_boundary = &r_phase;
  assign w_push     = sample_valid_in & r_ready;
  assign w_pop      = w_boundary & ~w_empty;
  assign w_cur_new  = w_pop ? r_mem[r_rptr] : r_cur;

  // Occupancy after this cycle's push/pop.
  always_comb begin
    w_count_next = r_count;
    unique case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + 1'b1;
      2'b01:   w_count_next = r_count - 1'b1;
      default: w_count_next = r_count;
    endcase
  end

  // Sample storage; pointers gate validity, so no reset.
  always_ff @(posedge clk_in) begin
    if (w_push) r_mem[r_wptr] <= sample_in;
  end

  // FIFO pointers, count and registered ready.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_ready <= 1'b1;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      r_count <= w_count_next;
      r_ready <= (w_count_next != FULL);
    end
  end

  // Phase, boundary tick, current sample and sticky underrun.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_phase    <= '0;
      r_cur      <= '0;
      r_tick     <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      r_phase <= r_phase + 1'b1;
      r_tick  <= w_boundary;
      r_cur   <= w_cur_new;
      if (w_boundary && w_empty)
        r_underrun <= 1'b1;
      else if (clear_underrun_in)
        r_underrun <= 1'b0;
    end
  end

`ifdef PDM_FEEDER_INTERP_EN
  localparam int AW = WIDTH + 1 + OSR_LOG2;

  logic signed [AW-1:0] r_acc;
  logic signed [WIDTH:0] r_step;
  logic [AW-1:0]        w_acc_load;
  logic [WIDTH:0]       w_step_new;

  // The outgoing cur is the new segment's start point.
  assign w_acc_load =
    {{(OSR_LOG2+1){r_cur[WIDTH-1]}}, r_cur} << OSR_LOG2;
  assign w_step_new =
    {w_cur_new[WIDTH-1], w_cur_new} -
    {r_cur[WIDTH-1], r_cur};
  assign w_y = r_acc[OSR_LOG2 +: WIDTH];

  // Ramp accumulator: reload at boundary, step otherwise.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_acc  <= '0;
      r_step <= '0;
    end else if (w_boundary) begin
      r_acc  <= w_acc_load;
      r_step <= w_step_new;
    end else begin
      r_acc <= r_acc + {{OSR_LOG2{r_step[WIDTH]}}, r_step};
    end
  end
`else
  assign w_y = r_cur;
`endif

  // Offset-binary output level, midscale at reset.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) r_level <= MID;
    else           r_level <= {~w_y[WIDTH-1], w_y[WIDTH-2:0]};
  end

  assign sample_ready_out = r_ready;
  assign level_out        = r_level;
  assign tick_out         = r_tick;
  assign underrun_out     = r_underrun;
  assign fifo_count_out   = r_count;

endmodule

// File: tb/tb_pdm_sample_feeder.sv
// tb_pdm_sample_feeder: directed checks, WIDTH=16 OSR_LOG2=2 DEPTH=4.
// Interpolation checks run when PDM_FEEDER_INTERP_EN is defined.
module tb_pdm_sample_feeder;

  logic        clk;
  logic        rst_n;
  logic [15:0] sample;
  logic        valid;
  logic        ready;
  logic [15:0] level;
  logic        tick;
  logic        underrun;
  logic        clear;
  logic [2:0]  count;

  int checks = 0;
  int errors = 0;

  pdm_sample_feeder #(
    .WIDTH(16), .OSR_LOG2(2), .FIFO_DEPTH(4)
  ) dut (
    .clk_in(clk),
    .rst_n_in(rst_n),
    .sample_in(sample),
    .sample_valid_in(valid),
    .sample_ready_out(ready),
    .level_out(level),
    .tick_out(tick),
    .underrun_out(underrun),
    .clear_underrun_in(clear),
    .fifo_count_out(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reset, then release in the phase-0 cycle before edge P1.
  task automatic do_reset();
    rst_n = 1'b0;
    valid = 1'b0;
    clear = 1'b0;
    sample = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (level !== 16'h8000) begin
      errors++;
      $display("FAIL reset_level got %h want 8000", level);
    end
    checks++;
    if (ready !== 1'b1 || count !== 3'd0) begin
      errors++;
      $display("FAIL reset_fifo got ready=%b count=%0d want 1/0",
               ready, count);
    end
    checks++;
    if (underrun !== 1'b0 || tick !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags got ur=%b tick=%b want 0/0",
               underrun, tick);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    valid = 1'b1;
    sample = 16'h0100; step();
    sample = 16'h0200; step();
    sample = 16'h0300; step();
    checks++;
    if (count !== 3'd3) begin
      errors++;
      $display("FAIL b2b_p3_count got %0d want 3", count);
    end
    sample = 16'h0400; step();
    checks++;
    if (count !== 3'd3 || tick !== 1'b1) begin
      errors++;
      $display("FAIL b2b_p4 got count=%0d tick=%b want 3/1",
               count, tick);
    end
    sample = 16'h0500; step();
    checks++;
    if (count !== 3'd4 || ready !== 1'b0) begin
      errors++;
      $display("FAIL b2b_full got count=%0d ready=%b want 4/0",
               count, ready);
    end
`ifndef PDM_FEEDER_INTERP_EN
    checks++;
    if (level !== 16'h8100) begin
      errors++;
      $display("FAIL b2b_level0 got %h want 8100", level);
    end
`endif
    sample = 16'h0600;
    step(); step();
    checks++;
    if (count !== 3'd4 || ready !== 1'b0) begin
      errors++;
      $display("FAIL b2b_hold got count=%0d ready=%b want 4/0",
               count, ready);
    end
    step();
    checks++;
    if (count !== 3'd3 || ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_pop got count=%0d ready=%b want 3/1",
               count, ready);
    end
    step();
    valid = 1'b0;
    checks++;
    if (count !== 3'd4 || ready !== 1'b0) begin
      errors++;
      $display("FAIL b2b_refill got count=%0d ready=%b want 4/0",
               count, ready);
    end
`ifndef PDM_FEEDER_INTERP_EN
    checks++;
    if (level !== 16'h8200) begin
      errors++;
      $display("FAIL b2b_level1 got %h want 8200", level);
    end
`endif
  endtask

`ifndef PDM_FEEDER_INTERP_EN
  task automatic test_hold();
    do_reset();
    valid = 1'b1;
    sample = 16'h1000;
    step();
    valid = 1'b0;
    step(); step(); step();
    checks++;
    if (level !== 16'h8000) begin
      errors++;
      $display("FAIL hold_pre got %h want 8000", level);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (level !== 16'h9000) begin
        errors++;
        $display("FAIL hold_seg[%0d] got %h want 9000", i, level);
      end
    end
  endtask

  task automatic test_extremes();
    do_reset();
    valid = 1'b1;
    sample = 16'h8000; step();
    sample = 16'h7FFF; step();
    valid = 1'b0;
    step(); step(); step();
    checks++;
    if (level !== 16'h0000) begin
      errors++;
      $display("FAIL ext_min got %h want 0000", level);
    end
    step(); step(); step();
    checks++;
    if (level !== 16'h0000) begin
      errors++;
      $display("FAIL ext_min_held got %h want 0000", level);
    end
    step();
    checks++;
    if (level !== 16'hFFFF) begin
      errors++;
      $display("FAIL ext_max got %h want FFFF", level);
    end
  endtask
`else
  task automatic test_interp();
    logic [15:0] exp_lv [5];
    exp_lv[0] = 16'h8000;
    exp_lv[1] = 16'h8100;
    exp_lv[2] = 16'h8200;
    exp_lv[3] = 16'h8300;
    exp_lv[4] = 16'h8400;
    do_reset();
    valid = 1'b1;
    sample = 16'h0400;
    step();
    valid = 1'b0;
    step(); step(); step();
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (level !== exp_lv[i]) begin
        errors++;
        $display("FAIL interp[%0d] got %h want %h",
                 i, level, exp_lv[i]);
      end
    end
    step();
    checks++;
    if (level !== 16'h8400) begin
      errors++;
      $display("FAIL interp_hold got %h want 8400", level);
    end
  endtask
`endif

  task automatic test_underrun();
    do_reset();
    step(); step(); step();
    checks++;
    if (tick !== 1'b0 || underrun !== 1'b0) begin
      errors++;
      $display("FAIL ur_pre got tick=%b ur=%b want 0/0",
               tick, underrun);
    end
    step();
    checks++;
    if (tick !== 1'b1 || underrun !== 1'b1) begin
      errors++;
      $display("FAIL ur_set got tick=%b ur=%b want 1/1",
               tick, underrun);
    end
    step();
    checks++;
    if (tick !== 1'b0 || level !== 16'h8000) begin
      errors++;
      $display("FAIL ur_hold got tick=%b lvl=%h want 0/8000",
               tick, level);
    end
    clear = 1'b1;
    step();
    clear = 1'b0;
    checks++;
    if (underrun !== 1'b0) begin
      errors++;
      $display("FAIL ur_clear got %b want 0", underrun);
    end
    step();
    clear = 1'b1;
    step();
    clear = 1'b0;
    checks++;
    if (underrun !== 1'b1 || level !== 16'h8000) begin
      errors++;
      $display("FAIL ur_prio got ur=%b lvl=%h want 1/8000",
               underrun, level);
    end
  endtask

  task automatic test_reset_midstream();
    do_reset();
    valid = 1'b1;
    sample = 16'h2000; step();
    sample = 16'h3000; step();
    valid = 1'b0;
    repeat (4) step();
    checks++;
    if (count !== 3'd1) begin
      errors++;
      $display("FAIL mid_count got %0d want 1", count);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (level !== 16'h8000 || count !== 3'd0 ||
        ready !== 1'b1 || underrun !== 1'b0 || tick !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset got lvl=%h cnt=%0d rdy=%b ur=%b tk=%b",
               level, count, ready, underrun, tick);
    end
    valid = 1'b1;
    sample = 16'h1234;
    step();
    checks++;
    if (count !== 3'd0) begin
      errors++;
      $display("FAIL mid_nopush got %0d want 0", count);
    end
    valid = 1'b0;
    rst_n = 1'b1;
    step();
    checks++;
    if (count !== 3'd0 || level !== 16'h8000) begin
      errors++;
      $display("FAIL mid_after got cnt=%0d lvl=%h want 0/8000",
               count, level);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    valid = 1'b0;
    clear = 1'b0;
    sample = '0;
    test_reset();
    test_back_to_back();
`ifndef PDM_FEEDER_INTERP_EN
    test_hold();
    test_extremes();
`else
    test_interp();
`endif
    test_underrun();
    test_reset_midstream();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
